// File: rtl/huff_code_gen.sv
// huff_code_gen: Huffman code generator.
// Takes N symbol counts in one handshake. It builds the Huffman tree one merge
// per cycle. Ties are broken by (weight, id), and merged nodes carry ids N, N+1, ...
// It then assigns canonical codes one symbol per cycle, in (len, index) order.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       count handshake; in_ready only while idle
//   cnt_i [N*W]             counts, symbol k at [k*W +: W]
//   out_valid/out_ready     result handshake; results held until accepted
//   code_o/mask_o [N*L]     right-aligned canonical code and len-LSB mask per symbol
//   len_o [N*LW]            code length per symbol
//   err_o [2]               bit0: all counts zero, bit1: a length exceeded L
module huff_code_gen #(
  parameter int N  = 6,
  parameter int W  = 8,
  parameter int L  = 8,
  parameter int LW = $clog2(L+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  cnt_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*L-1:0]  code_o,
  output logic [N*L-1:0]  mask_o,
  output logic [N*LW-1:0] len_o,
  output logic [1:0]      err_o
);
  localparam int WW = W + $clog2(N);  // merged weight never overflows
  localparam int IW = $clog2(2*N);    // node ids 0 .. 2N-2
  localparam int CW = $clog2(N) + 1;  // raw tree depth, up to N-1
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, MERGE, LEN_CHK, CANON, DONE} state_t;
  state_t state, state_n;

  // Node slots: a merge writes the combined node into the slot of the
  // smaller node and frees the other slot, so N slots are enough.
  logic [N-1:0][WW-1:0] wt;
  logic [N-1:0][IW-1:0] nid;
  logic [N-1:0][N-1:0]  mem;
  logic [N-1:0]         live;
  logic [N-1:0][CW-1:0] lens;
  logic [N-1:0]         placed;
  logic [IW-1:0]        midx;
  logic [L-1:0]         prev_code;
  logic [CW-1:0]        prev_len;
  logic                 first;

  logic [SW-1:0] a, b, s;
  logic          a_ok, b_ok, s_ok;
  logic [SW:0]   n_live, n_rem;
  logic          over;
  logic [N-1:0]  mu;
  logic [L-1:0]  c_code, c_mask;

  // Two smallest live nodes by (weight, id).
  always_comb begin
    a = '0; b = '0; a_ok = 1'b0; b_ok = 1'b0; n_live = '0;
    for (int i = 0; i < N; i++)
      if (live[i]) begin
        n_live = n_live + (SW+1)'(1);
        if (!a_ok || {wt[i], nid[i]} < {wt[a], nid[a]}) begin
          a = SW'(i); a_ok = 1'b1;
        end
      end
    for (int i = 0; i < N; i++)
      if (live[i] && SW'(i) != a && (!b_ok || {wt[i], nid[i]} < {wt[b], nid[b]})) begin
        b = SW'(i); b_ok = 1'b1;
      end
    mu = mem[a] | mem[b];
  end

  // Next symbol for canonical assignment and length-overflow detection.
  always_comb begin
    s = '0; s_ok = 1'b0; n_rem = '0; over = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (32'(lens[i]) > L) over = 1'b1;
      if (lens[i] != '0 && !placed[i]) begin
        n_rem = n_rem + (SW+1)'(1);
        // ascending scan with strict '<' keeps the lower index on equal length
        if (!s_ok || lens[i] < lens[s]) begin
          s = SW'(i); s_ok = 1'b1;
        end
      end
    end
    c_code = first ? '0 : (prev_code + L'(1)) << (lens[s] - prev_len);
    c_mask = ~({L{1'b1}} << lens[s]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = MERGE;
      MERGE:   if (n_live == '0) state_n = DONE;
               else if (n_live == (SW+1)'(1)) state_n = LEN_CHK;
      LEN_CHK: state_n = over ? DONE : CANON;
      CANON:   if (n_rem <= (SW+1)'(1)) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      wt <= '0; nid <= '0; mem <= '0; live <= '0; lens <= '0; placed <= '0;
      midx <= '0; prev_code <= '0; prev_len <= '0; first <= 1'b1;
      code_o <= '0; mask_o <= '0; len_o <= '0; err_o <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          for (int k = 0; k < N; k++) begin
            wt[k]   <= WW'(cnt_i[k*W +: W]);
            nid[k]  <= IW'(k);
            mem[k]  <= N'(1) << k;
            live[k] <= (cnt_i[k*W +: W] != '0);
          end
          lens <= '0; placed <= '0; midx <= '0; first <= 1'b1;
          code_o <= '0; mask_o <= '0; len_o <= '0; err_o <= '0;
        end
        MERGE: begin
          if (n_live > (SW+1)'(1)) begin
            wt[a]   <= wt[a] + wt[b];
            nid[a]  <= IW'(N) + midx;
            mem[a]  <= mu;
            live[b] <= 1'b0;
            midx    <= midx + IW'(1);
            for (int k = 0; k < N; k++)
              if (mu[k]) lens[k] <= lens[k] + CW'(1);
          end else if (n_live == '0) begin
            err_o[0] <= 1'b1;
          end else if (midx == '0) begin
            // a lone symbol still needs one bit
            for (int k = 0; k < N; k++)
              if (mem[a][k]) lens[k] <= CW'(1);
          end
        end
        LEN_CHK: if (over) err_o[1] <= 1'b1;
        CANON: if (s_ok) begin
          code_o[s*L +: L]  <= c_code;
          mask_o[s*L +: L]  <= c_mask;
          len_o[s*LW +: LW] <= LW'(lens[s]);
          prev_code <= c_code;
          prev_len  <= lens[s];
          first     <= 1'b0;
          placed[s] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_huff_code_gen.sv
module tb_huff_code_gen;
  localparam int N = 6, W = 8, L1 = 8, L2 = 4;
  localparam int LW1 = $clog2(L1+1), LW2 = $clog2(L2+1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N*W-1:0] cnt;
  logic iv1, ir1, ov1, or1, iv2, ir2, ov2, or2;
  logic [N*L1-1:0] code1, mask1;
  logic [N*LW1-1:0] len1;
  logic [1:0] err1, err2;
  logic [N*L2-1:0] code2, mask2;
  logic [N*LW2-1:0] len2;

  huff_code_gen #(.N(N), .W(W), .L(L1)) dut (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .cnt_i(cnt),
    .out_valid(ov1), .out_ready(or1), .code_o(code1), .mask_o(mask1),
    .len_o(len1), .err_o(err1));

  huff_code_gen #(.N(N), .W(W), .L(L2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .cnt_i(cnt),
    .out_valid(ov2), .out_ready(or2), .code_o(code2), .mask_o(mask2),
    .len_o(len2), .err_o(err2));

  int checks = 0, errors = 0;

  typedef struct {longint w; int id; int m;} node_t;

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit less(input node_t x, input node_t y);
    return (x.w < y.w) || (x.w == y.w && x.id < y.id);
  endfunction

  // Reference: build the tree from a list of nodes, then assign canonical
  // codes by walking lengths shortest-first, symbols in index order.
  task automatic model(input int c[N], input int lmax, output int el[N],
                       output int ec[N], output int em[N], output int eerr);
    node_t q[$];
    node_t nn;
    int nid, i0, i1, prev, plen;
    bit first;
    eerr = 0;
    for (int k = 0; k < N; k++) begin el[k] = 0; ec[k] = 0; em[k] = 0; end
    for (int k = 0; k < N; k++)
      if (c[k] != 0) begin nn.w = c[k]; nn.id = k; nn.m = 1 << k; q.push_back(nn); end
    if (q.size() == 0) begin eerr = 1; return; end
    if (q.size() == 1)
      for (int k = 0; k < N; k++) if (((q[0].m >> k) & 1) != 0) el[k] = 1;
    nid = N;
    while (q.size() > 1) begin
      i0 = 0;
      for (int j = 1; j < q.size(); j++) if (less(q[j], q[i0])) i0 = j;
      i1 = (i0 == 0) ? 1 : 0;
      for (int j = 0; j < q.size(); j++) if (j != i0 && less(q[j], q[i1])) i1 = j;
      nn.w = q[i0].w + q[i1].w; nn.id = nid; nn.m = q[i0].m | q[i1].m;
      nid++;
      for (int k = 0; k < N; k++) if (((nn.m >> k) & 1) != 0) el[k]++;
      if (i0 > i1) begin q.delete(i0); q.delete(i1); end
      else begin q.delete(i1); q.delete(i0); end
      q.push_back(nn);
    end
    for (int k = 0; k < N; k++) if (el[k] > lmax) eerr = 2;
    if (eerr != 0) begin
      for (int k = 0; k < N; k++) el[k] = 0;
      return;
    end
    first = 1; prev = 0; plen = 0;
    for (int len = 1; len <= 16; len++)
      for (int k = 0; k < N; k++)
        if (el[k] == len) begin
          ec[k] = first ? 0 : ((prev + 1) << (len - plen));
          em[k] = (1 << len) - 1;
          prev = ec[k]; plen = len; first = 0;
        end
  endtask

  task automatic load(input int c[N]);
    for (int k = 0; k < N; k++) cnt[k*W +: W] = c[k][W-1:0];
  endtask

  // One full transaction on dut (sel=0) or dut_s (sel=1), checked against the model.
  task automatic run(input bit sel, input int c[N], input string tag);
    int el[N], ec[N], em[N];
    int eerr, lat;
    model(c, sel ? L2 : L1, el, ec, em, eerr);
    load(c);
    if (sel) iv2 = 1'b1; else iv1 = 1'b1;
    step;
    iv1 = 1'b0; iv2 = 1'b0; lat = 0;
    while (!(sel ? ov2 : ov1) && lat < 4*N + 8) begin step; lat++; end
    chk($sformatf("%s out_valid", tag), sel ? ov2 : ov1, 1);
    chk($sformatf("%s latency=%0d", tag, lat), lat <= 2*N + 4, 1);
    chk($sformatf("%s err", tag), sel ? err2 : err1, eerr);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s code%0d", tag, k), sel ? code2[k*L2 +: L2] : code1[k*L1 +: L1], ec[k]);
      chk($sformatf("%s mask%0d", tag, k), sel ? mask2[k*L2 +: L2] : mask1[k*L1 +: L1], em[k]);
      chk($sformatf("%s len%0d", tag, k), sel ? len2[k*LW2 +: LW2] : len1[k*LW1 +: LW1], el[k]);
    end
    if (sel) or2 = 1'b1; else or1 = 1'b1;
    step;
    or1 = 1'b0; or2 = 1'b0;
    chk($sformatf("%s in_ready after accept", tag), sel ? ir2 : ir1, 1);
    chk($sformatf("%s out_valid after accept", tag), sel ? ov2 : ov1, 0);
  endtask

  initial begin
    int c[N];
    int el[N], ec[N], em[N];
    int eerr, lat;
    logic [N*L1-1:0] xcode, xmask;
    logic [N*LW1-1:0] xlen;

    reset = 1'b1; iv1 = 0; or1 = 0; iv2 = 0; or2 = 0; cnt = '0;
    step; step;
    chk("reset in_ready", ir1, 1);
    chk("reset out_valid", ov1, 0);
    chk("reset code", code1, 0);
    chk("reset mask", mask1, 0);
    chk("reset len", len1, 0);
    chk("reset err", err1, 0);
    reset = 1'b0;
    step;

    c = '{1, 2, 4, 8, 16, 32};  run(0, c, "powers");
    c = '{5, 5, 5, 5, 5, 5};    run(0, c, "ties");
    c = '{0, 0, 0, 7, 0, 0};    run(0, c, "single");
    c = '{0, 0, 0, 0, 0, 0};    run(0, c, "allzero");
    c = '{1, 2, 4, 8, 16, 32};  run(1, c, "overlen");
    c = '{5, 5, 5, 5, 5, 5};    run(1, c, "ties_l4");

    // Consumer stalls: results held, loads ignored.
    c = '{5, 5, 5, 5, 5, 5};
    model(c, L1, el, ec, em, eerr);
    for (int k = 0; k < N; k++) begin
      xcode[k*L1 +: L1] = L1'(ec[k]);
      xmask[k*L1 +: L1] = L1'(em[k]);
      xlen[k*LW1 +: LW1] = LW1'(el[k]);
    end
    load(c); iv1 = 1'b1; step; iv1 = 1'b0; lat = 0;
    while (!ov1 && lat < 4*N + 8) begin step; lat++; end
    chk("stall out_valid", ov1, 1);
    for (int i = 0; i < 5; i++) begin
      cnt = N*W'($urandom); iv1 = i[0];
      step;
      chk($sformatf("stall%0d out_valid", i), ov1, 1);
      chk($sformatf("stall%0d in_ready", i), ir1, 0);
      chk($sformatf("stall%0d code", i), code1, xcode);
      chk($sformatf("stall%0d mask", i), mask1, xmask);
      chk($sformatf("stall%0d len", i), len1, xlen);
    end
    iv1 = 1'b0; or1 = 1'b1; step; or1 = 1'b0;
    chk("stall accept in_ready", ir1, 1);
    chk("stall accept out_valid", ov1, 0);
    chk("stall held code", code1, xcode);
    step;
    chk("stall no phantom load", ir1, 1);

    // Reset during MERGE.
    c = '{1, 2, 4, 8, 16, 32};
    load(c); iv1 = 1'b1; step; iv1 = 1'b0; step;
    reset = 1'b1; step; reset = 1'b0;
    chk("midreset in_ready", ir1, 1);
    chk("midreset out_valid", ov1, 0);
    chk("midreset code", code1, 0);
    chk("midreset len", len1, 0);
    chk("midreset err", err1, 0);
    c = '{5, 5, 5, 5, 5, 5};    run(0, c, "after_reset");

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < N; k++)
        c[k] = ($urandom_range(0, 3) == 0) ? 0 :
               (t[0] ? $urandom_range(1, 4) : $urandom_range(1, 255));
      run(0, c, $sformatf("rnd%0d", t));
    end
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < N; k++) c[k] = 1 << $urandom_range(0, 7);
      run(1, c, $sformatf("rnd_l4_%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
